// File: rtl/ring_johnson_if.sv
// Control and status bundle for ring_johnson_counter.
// The master drives the step controls and the slave returns the sequence state.
interface ring_johnson_if #(
   parameter int unsigned WIDTH = 6
);
   localparam int unsigned IW = $clog2(2 * WIDTH);

   logic             en;
   logic             mode;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic [IW-1:0]    index;
   logic             wrap;
   logic             err;

   modport master (
      output en, mode, up, load, load_val,
      input  count, index, wrap, err
   );

   modport slave (
      input  en, mode, up, load, load_val,
      output count, index, wrap, err
   );
endinterface

// File: rtl/ring_johnson_counter.sv
// One-hot ring / Johnson sequence counter with run-time mode and direction,
// synchronous load, a wrap strobe, and self-correction of illegal states.
module ring_johnson_counter #(
   parameter int unsigned WIDTH = 6
) (
   input logic           clk,
   input logic           rst,
   ring_johnson_if.slave bus
);
   localparam int unsigned      IW      = $clog2(2 * WIDTH);
   localparam logic [WIDTH-1:0] RST_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] step;
   logic             wrap_q;
   logic             wrap_nxt;
   logic             err_q;
   logic             err_nxt;
   logic [IW-1:0]    last_idx;
   logic [IW-1:0]    wrap_pt;

   // Johnson states are contiguous runs of ones anchored at either end.
   function automatic logic is_legal(input logic [WIDTH-1:0] c, input logic m);
      logic [WIDTH-1:0] nc;
      nc = ~c;
      if (m)
         return ((c & WIDTH'(c + ONE)) == '0) || ((nc & WIDTH'(nc + ONE)) == '0);
      return (c != '0) && ((c & WIDTH'(c - ONE)) == '0);
   endfunction

   function automatic int unsigned popcnt(input logic [WIDTH-1:0] c);
      int unsigned p;
      p = 0;
      for (int i = 0; i < int'(WIDTH); i++) p += 32'(c[i]);
      return p;
   endfunction

   function automatic logic [IW-1:0] index_of(input logic [WIDTH-1:0] c, input logic m);
      logic [IW-1:0] r;
      r = '0;
      if (!m) begin
         for (int i = 0; i < int'(WIDTH); i++)
            if (c[i]) r = IW'(WIDTH - 1 - 32'(i));
      end else if (c[WIDTH-1]) begin
         r = IW'(popcnt(c));
      end else if (c != '0) begin
         r = IW'(2 * WIDTH - popcnt(c));
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RST_VAL;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         wrap_q  <= wrap_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      step = count_q;
      if (bus.mode)
         step = bus.up ? {~count_q[0], count_q[WIDTH-1:1]}
                       : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      else
         step = bus.up ? {count_q[0], count_q[WIDTH-1:1]}
                       : {count_q[WIDTH-2:0], count_q[WIDTH-1]};
   end

   assign last_idx = bus.mode ? IW'(2 * WIDTH - 1) : IW'(WIDTH - 1);
   assign wrap_pt  = bus.up ? '0 : last_idx;

   // Priority: load, then illegal-state correction, then step, else hold.
   always_comb begin
      count_nxt = count_q;
      wrap_nxt  = 1'b0;
      err_nxt   = err_q;
      if (bus.load) begin
         if (is_legal(bus.load_val, bus.mode)) begin
            count_nxt = bus.load_val;
         end else begin
            count_nxt = RST_VAL;
            err_nxt   = 1'b1;
         end
      end else if (!is_legal(count_q, bus.mode)) begin
         count_nxt = RST_VAL;
         err_nxt   = 1'b1;
      end else if (bus.en) begin
         count_nxt = step;
         wrap_nxt  = (index_of(step, bus.mode) == wrap_pt);
      end
   end

   always_comb begin
      bus.count = count_q;
      bus.index = index_of(count_q, bus.mode);
      bus.wrap  = wrap_q;
      bus.err   = err_q;
   end
endmodule
